// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, data requester and memory port signals around mem_port_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
               mem_addr, mem_wdata, mem_wr_en, mem_rd_en
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
               mem_addr, mem_wdata, mem_wr_en, mem_rd_en
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store traffic.
// Build macro MEM_ARB_RR_EN swaps the data-priority streak guard for round-robin tie breaking.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic              pick_d;
    logic              owner_d;
    logic              we_q;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

`ifdef MEM_ARB_RR_EN
    logic              last_d;
`else
    logic [3:0]        streak;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        pick_d    = 1'b0;
        win_addr  = bus.if_addr;
        win_wdata = '0;
        case (state)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    grant     = 1'b1;
`ifdef MEM_ARB_RR_EN
                    pick_d    = bus.d_req && (!bus.if_req || !last_d);
`else
                    // Data wins unless fetch has already waited out MAX_D_STREAK data grants.
                    pick_d    = bus.d_req && !(bus.if_req && streak == 4'(MAX_D_STREAK));
`endif
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = (owner_d && we_q) ? IDLE : RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (pick_d) begin
            win_addr  = bus.d_addr;
            win_wdata = bus.d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_d       <= 1'b0;
            we_q          <= 1'b0;
            bus.if_gnt    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_valid  <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_valid   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wr_en <= 1'b0;
            bus.mem_rd_en <= 1'b0;
        end else begin
            bus.if_gnt    <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.if_valid  <= 1'b0;
            bus.d_valid   <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    // Operands are captured here so requesters may change them after gnt.
                    if (grant) begin
                        owner_d       <= pick_d;
                        we_q          <= pick_d && bus.d_we;
                        bus.if_gnt    <= !pick_d;
                        bus.d_gnt     <= pick_d;
                        bus.mem_addr  <= win_addr;
                        bus.mem_wdata <= win_wdata;
                        bus.mem_rd_en <= !(pick_d && bus.d_we);
                        bus.mem_wr_en <= pick_d && bus.d_we;
                    end
                end
                ISSUE: begin
                    if (owner_d && we_q) bus.d_valid <= 1'b1;
                end
                RESP: begin
                    if (owner_d) begin
                        bus.d_rdata  <= bus.mem_rdata;
                        bus.d_valid  <= 1'b1;
                    end else begin
                        bus.if_rdata <= bus.mem_rdata;
                        bus.if_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Reset value points at fetch so data wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       last_d <= 1'b0;
        else if (grant) last_d <= pick_d;
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (grant) begin
            if (!pick_d || !bus.if_req)            streak <= '0;
            else if (streak != 4'(MAX_D_STREAK))   streak <= streak + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
`ifdef MEM_ARB_RR_EN
  localparam logic [9:0] EXP_ORDER = 10'b1010101010;
`else
  localparam logic [9:0] EXP_ORDER = 10'b1111011110;
`endif

  typedef struct {
    int          cyc;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    int          cyc;
    bit          load;
    logic [31:0] data;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // synchronous memory: read data appears the cycle after mem_rd_en
  logic [31:0] mem_arr [0:511];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem_arr[bus.mem_addr[8:0]] = bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mem_arr[bus.mem_addr[8:0]];
  end

  // reference model state
  logic [31:0] ref_mem [0:511];
  gexp_t exp_g_q[$];
  rexp_t exp_if_q[$];
  rexp_t exp_d_q[$];
  logic [31:0] ref_if = '0;
  logic [31:0] ref_d  = '0;
  int busy_left = 0;
`ifdef MEM_ARB_RR_EN
  bit last_f = 1'b1;
`else
  int d_run = 0;
`endif

  // requester state
  bit          f_pend = 1'b0;
  bit          d_pend = 1'b0;
  logic [31:0] f_addr = '0;
  bit          d_we_r = 1'b0;
  logic [31:0] d_addr_r = '0;
  logic [31:0] d_wdata_r = '0;

  bit          collect = 1'b0;
  int          nlog = 0;
  logic [9:0]  glog = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void miss(string name, string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endfunction

  // scoreboard monitor
  gexp_t mg;
  rexp_t mr;
  always @(negedge clk) begin
    if (rst) begin
      while (exp_g_q.size() > 0 && exp_g_q[0].cyc < cyc) begin
        mg = exp_g_q.pop_front();
        miss("grant_missing", "got no grant, required one");
      end
      if (exp_g_q.size() > 0 && exp_g_q[0].cyc == cyc) begin
        mg = exp_g_q.pop_front();
        chk("gnt", 64'({bus.if_gnt, bus.d_gnt}), mg.is_d ? 64'd1 : 64'd2);
        chk("strobe", 64'({bus.mem_rd_en, bus.mem_wr_en}), mg.we ? 64'd1 : 64'd2);
        chk("mem_addr", 64'(bus.mem_addr), 64'(mg.addr));
        if (mg.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(mg.wdata));
        if (collect && nlog < 10) begin
          glog = {glog[8:0], bus.d_gnt};
          nlog++;
        end
      end else if (bus.if_gnt || bus.d_gnt || bus.mem_rd_en || bus.mem_wr_en) begin
        miss("spurious_grant", "got grant/strobe, required none");
      end

      while (exp_if_q.size() > 0 && exp_if_q[0].cyc < cyc) begin
        mr = exp_if_q.pop_front();
        miss("if_valid_missing", "got no if_valid, required one");
      end
      if (exp_if_q.size() > 0 && exp_if_q[0].cyc == cyc) begin
        mr = exp_if_q.pop_front();
        chk("if_valid", 64'(bus.if_valid), 64'd1);
        chk("if_rdata", 64'(bus.if_rdata), 64'(mr.data));
        ref_if = mr.data;
        chk("d_rdata_hold", 64'(bus.d_rdata), 64'(ref_d));
      end else if (bus.if_valid) begin
        miss("spurious_if_valid", "got if_valid, required none");
      end

      while (exp_d_q.size() > 0 && exp_d_q[0].cyc < cyc) begin
        mr = exp_d_q.pop_front();
        miss("d_valid_missing", "got no d_valid, required one");
      end
      if (exp_d_q.size() > 0 && exp_d_q[0].cyc == cyc) begin
        mr = exp_d_q.pop_front();
        chk("d_valid", 64'(bus.d_valid), 64'd1);
        if (mr.load) begin
          chk("d_rdata", 64'(bus.d_rdata), 64'(mr.data));
          ref_d = mr.data;
        end else begin
          chk("d_rdata_store_hold", 64'(bus.d_rdata), 64'(ref_d));
        end
        chk("if_rdata_hold", 64'(bus.if_rdata), 64'(ref_if));
      end else if (bus.d_valid) begin
        miss("spurious_d_valid", "got d_valid, required none");
      end
    end
  end

  // arbitration rule applied to the current requests whenever the port is free
  task automatic decide();
    bit          pick_d;
    logic [31:0] a;
    if (busy_left != 0 || !(f_pend || d_pend)) return;
`ifdef MEM_ARB_RR_EN
    pick_d = d_pend && (!f_pend || last_f);
    last_f = !pick_d;
`else
    pick_d = d_pend && !(f_pend && d_run >= MAXS);
    d_run  = (pick_d && f_pend) ? d_run + 1 : 0;
`endif
    a = pick_d ? d_addr_r : f_addr;
    exp_g_q.push_back('{cyc + 1, pick_d, pick_d && d_we_r, a, d_wdata_r});
    if (pick_d && d_we_r) begin
      exp_d_q.push_back('{cyc + 2, 1'b0, 32'h0});
      ref_mem[a[8:0]] = d_wdata_r;
      busy_left = 2;
    end else begin
      if (pick_d) exp_d_q.push_back('{cyc + 3, 1'b1, ref_mem[a[8:0]]});
      else        exp_if_q.push_back('{cyc + 3, 1'b1, ref_mem[a[8:0]]});
      busy_left = 3;
    end
  endtask

  task automatic react();
    if (busy_left > 0) busy_left--;
    if (bus.if_valid) f_pend = 1'b0;
    if (bus.d_valid)  d_pend = 1'b0;
    if (bus.if_gnt) bus.if_addr = $urandom;
    if (bus.d_gnt) begin
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
    end
  endtask

  task automatic new_fetch(input logic [31:0] a);
    f_pend = 1'b1;
    f_addr = a;
    bus.if_addr = a;
  endtask

  task automatic new_data(input bit we, input logic [31:0] a, input logic [31:0] w);
    d_pend    = 1'b1;
    d_we_r    = we;
    d_addr_r  = a;
    d_wdata_r = w;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = w;
  endtask

  task automatic drive_req();
    bus.if_req = f_pend;
    bus.d_req  = d_pend;
  endtask

  task automatic step(input int pf, input int pd);
    @(posedge clk); #1;
    react();
    if (!f_pend && $urandom_range(99) < pf) new_fetch(32'h100 + 32'($urandom_range(255)));
    if (!d_pend && $urandom_range(99) < pd)
      new_data(1'($urandom_range(1)), 32'($urandom_range(255)), $urandom);
    drive_req();
    decide();
  endtask

  task automatic step_fetch(input logic [31:0] a);
    @(posedge clk); #1;
    react();
    new_fetch(a);
    drive_req();
    decide();
  endtask

  task automatic step_data(input bit we, input logic [31:0] a, input logic [31:0] w);
    @(posedge clk); #1;
    react();
    new_data(we, a, w);
    drive_req();
    decide();
  endtask

  function automatic bit outstanding();
    return f_pend || d_pend || busy_left != 0 ||
           exp_g_q.size() != 0 || exp_if_q.size() != 0 || exp_d_q.size() != 0;
  endfunction

  task automatic idle(input int n);
    int k;
    k = 0;
    while (outstanding() && k < n) begin
      step(0, 0);
      k++;
    end
    if (outstanding()) miss("drain_timeout", "got outstanding work, required none");
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ctrl"}, 64'({bus.if_gnt, bus.if_valid, bus.d_gnt, bus.d_valid,
                             bus.mem_wr_en, bus.mem_rd_en}), 64'd0);
    chk({tag, "_if_rdata"}, 64'(bus.if_rdata), 64'd0);
    chk({tag, "_d_rdata"}, 64'(bus.d_rdata), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
  endtask

  task automatic model_reset();
    exp_g_q.delete();
    exp_if_q.delete();
    exp_d_q.delete();
    ref_if = '0;
    ref_d  = '0;
    busy_left = 0;
    f_pend = 1'b0;
    d_pend = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_f = 1'b1;
`else
    d_run = 0;
`endif
  endtask

  initial begin
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.d_req = 1'b0;   bus.d_we = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
    for (int i = 0; i < 512; i++) begin
      mem_arr[i] = 32'(i) * 32'h9E37_79B1;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[9'h100] = 32'hDEAD_BEEF;  ref_mem[9'h100] = 32'hDEAD_BEEF;
    mem_arr[9'h020] = 32'h0000_00AA;  ref_mem[9'h020] = 32'h0000_00AA;

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;

    // directed fetch, store, load-with-operand-change, then fetch keeping d_rdata
    step_fetch(32'h100);
    idle(20);
    step_data(1'b1, 32'h40, 32'h1234_5678);
    idle(20);
    step_data(1'b0, 32'h20, 32'h0);
    idle(20);
    step_fetch(32'h104);
    idle(20);

    // both requesters saturated: check grant ordering
    collect = 1'b1;
    nlog = 0;
    repeat (80) step(100, 100);
    collect = 1'b0;
    idle(40);
    if (nlog < 10) miss("grant_order_count", "got fewer than 10 grants, required 10");
    else           chk("grant_order", 64'(glog), 64'(EXP_ORDER));

    // random traffic
    for (int blk = 0; blk < 15; blk++) begin
      int pf;
      int pd;
      pf = $urandom_range(100, 10);
      pd = $urandom_range(100, 10);
      repeat (100) step(pf, pd);
    end
    idle(40);

    // reset while a fetch is in RESP
    step_fetch(32'h180);
    step(0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_zero("mid_reset");
    model_reset();
    drive_req();
    repeat (3) begin
      @(negedge clk);
      chk("reset_quiet", 64'({bus.if_valid, bus.d_valid, bus.if_gnt, bus.d_gnt}), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step_fetch(32'h1C0);
    idle(20);
    step_data(1'b0, 32'h40, 32'h0);
    idle(20);
    repeat (200) step(60, 60);
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between the instruction-fetch path and the load/store data path driven by the core's control FSM.
- Uses a per-requester req/gnt/valid handshake and latches each request's address and data.
- Sequences each access through a small FSM.
- Fixed data-over-fetch priority, with a streak counter that prevents fetch starvation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, maximum consecutive data grants while if_req is pending (range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rdata  out  DATA_W  fetched word
- if_valid  out  1  one-cycle pulse: if_rdata valid
- d_req  in  1  data request; held high until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle pulse: load data valid, or store complete
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wr_en  out  1  memory write strobe
- mem_rd_en  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_rd_en

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, streak=0, owner=none.
  - All outputs 0, including mem_addr, mem_wdata and both rdata buses.
- Reset asserted mid-transaction: the access is dropped and no valid is issued; requesters re-request after reset.
- All outputs are registered; none are combinational from inputs.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req is high, choose a winner:
    - d_req wins unless if_req=1 and streak==MAX_D_STREAK, in which case fetch wins.
  - Latch the winner's addr, wdata and we.
  - Go to ISSUE. In that cycle: gnt=1 for the winner; mem_addr/mem_wdata driven; mem_rd_en=1 (load/fetch) or mem_wr_en=1 (store).
  - If no req is high, remain in IDLE with all strobes 0.
- ISSUE, read: go to RESP. mem_rd_en and gnt drop to 0.
- ISSUE, store: d_valid=1 next cycle; return to IDLE.
- RESP: capture mem_rdata into if_rdata or d_rdata; pulse the matching valid the next cycle; return to IDLE.
- Latency from req sampled in IDLE (cycle 0):
  - Read: gnt at cycle 1, valid at cycle 3.
  - Store: gnt at cycle 1, d_valid at cycle 2.
- A new request may be sampled in the same cycle that valid is high; back-to-back reads take 3 cycles each.
- Latched operands: requester may change addr/wdata after gnt; the arbiter uses the latched copy.
- rdata buses hold their last value until the next response to the same requester.
- Streak counter:
  - Increments on a data grant while if_req=1.
  - Cleared on a fetch grant, and on a data grant when if_req=0.
  - Saturates at MAX_D_STREAK.
- Simultaneous requests in IDLE: the priority rule above decides; the loser's req stays high and is served later.
- Requester deasserting req before its valid: unsupported; the arbiter still completes the access.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: the streak counter is removed. Simultaneous requests alternate by round-robin, with a last_owner flop (reset = fetch, so data wins the first tie).
- Undefined: fixed data priority with the MAX_D_STREAK guard, as above.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, mem returns 0xDEADBEEF → if_gnt at cycle 1; mem_rd_en=1 with mem_addr=0x100 at cycle 1; if_valid with if_rdata=0xDEADBEEF at cycle 3.
- d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 → mem_wr_en=1, mem_addr=0x40, mem_wdata=0x12345678 at cycle 1; d_valid at cycle 2; mem_rd_en stays 0.
- if_req and d_req both held high continuously, MAX_D_STREAK=4 → grant order D,D,D,D,F,D,D,D,D,F; no request is lost.
- Same stimulus with MEM_ARB_RR_EN defined → grant order D,F,D,F,...
- rst driven low during RESP of a fetch → all outputs 0 immediately; no if_valid; after release, an IDLE re-request completes normally.
- Load at 0x20 returns 0xAA; d_addr changed to 0x99 after d_gnt → mem_addr stays 0x20 and d_rdata=0xAA; a subsequent fetch leaves d_rdata at 0xAA.
